// File: rtl/wb_pkg.sv
// Shared widths and the register-file write request type.
package wb_pkg;

  localparam int unsigned REG_W    = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  // One write toward the register-file port
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] rd;
    logic [REG_W-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// FIFO of buffered MLU results {rd, data} with per-entry valid/rd exposed for the pending mask.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic [ADDR_W-1:0]              push_rd_i,
  input  logic [REG_W-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic [ADDR_W-1:0]              head_rd_o,
  output logic [REG_W-1:0]               head_data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [DEPTH-1:0]               entry_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]   entry_rd_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0]    rd_q, rd_d;
  logic [DEPTH-1:0][REG_W-1:0]     data_q, data_d;
  logic                            push_ok, pop_ok;

  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign push_ok       = push_i && !full_o;
  assign pop_ok        = pop_i && !empty_o;
  assign head_rd_o     = rd_q[rd_ptr_q];
  assign head_data_o   = data_q[rd_ptr_q];
  assign entry_valid_o = valid_q;
  assign entry_rd_o    = rd_q;

  // Next-state: write at tail, retire at head; pointers wrap modulo DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    rd_d     = rd_q;
    data_d   = data_q;
    if (push_ok) begin
      rd_d[wr_ptr_q]    = push_rd_i;
      data_d[wr_ptr_q]  = push_data_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Storage and pointer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges pipeline writeback (priority) and buffered MLU results onto the single regfile write port.
module regfile_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pipe_we,
  input  logic [ADDR_W-1:0]   pipe_rd,
  input  logic [REG_W-1:0]    pipe_data,
  output logic                pipe_hold,
  input  logic                mlu_valid,
  input  logic [ADDR_W-1:0]   mlu_rd,
  input  logic [REG_W-1:0]    mlu_data,
  output logic                mlu_ready,
  output logic                write_enable,
  output logic [ADDR_W-1:0]   rd_address,
  output logic [REG_W-1:0]    rd_data,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                conflict_err
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  logic                         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]            head_rd;
  logic [REG_W-1:0]             head_data;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_rd;
  logic [SC_W-1:0]              starve_cnt_q, starve_cnt_d;
  logic                         conflict_q, conflict_d;
  logic                         pipe_req;
  wb_req_t                      wr;

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock         (clock),
    .reset         (reset),
    .push_i        (fifo_push),
    .push_rd_i     (mlu_rd),
    .push_data_i   (mlu_data),
    .pop_i         (fifo_pop),
    .head_rd_o     (head_rd),
    .head_data_o   (head_data),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_rd_o    (entry_rd)
  );

  // Ready tracks only the registered full flag, so a same-cycle pop never makes room
  assign mlu_ready = !reset && !fifo_full;
  // Results for r0 are acknowledged but dropped
  assign fifo_push = mlu_valid && mlu_ready && (mlu_rd != '0);
  assign pipe_req  = pipe_we && (pipe_rd != '0);
  assign pipe_hold = !reset && !fifo_empty && (starve_cnt_q == SC_W'(STARVE_LIMIT));

  // Registers with a buffered result still waiting for the port
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_mask[entry_rd[i]] = 1'b1;
    end
  end

  // Port select: forced drain, then pipeline, then opportunistic drain
  always_comb begin
    wr       = '0;
    fifo_pop = 1'b0;
    if (!reset) begin
      if (pipe_hold) begin
        wr       = '{we: 1'b1, rd: head_rd, data: head_data};
        fifo_pop = 1'b1;
      end else if (pipe_req) begin
        wr = '{we: 1'b1, rd: pipe_rd, data: pipe_data};
      end else if (!fifo_empty) begin
        wr       = '{we: 1'b1, rd: head_rd, data: head_data};
        fifo_pop = 1'b1;
      end
    end
  end

  assign write_enable = wr.we;
  assign rd_address   = wr.rd;
  assign rd_data      = wr.data;
  assign conflict_err = conflict_q;

  // Starvation age of the FIFO head and sticky conflict flag
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    conflict_d   = conflict_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
    if (pipe_req && !pipe_hold && pending_mask[pipe_rd]) conflict_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      conflict_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      conflict_q   <= conflict_d;
    end
  end

endmodule
